// File: rtl/shift_pkg.sv
// Shared decode constants, shift kinds and FSM states for the multi-cycle shift unit.
package shift_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA, SK_ROR} shift_kind_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_shift_instr(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OPC_RTYPE) &&
           (funct == FUNCT_SLL  || funct == FUNCT_SRL  || funct == FUNCT_SRA ||
            funct == FUNCT_SLLV || funct == FUNCT_SRLV || funct == FUNCT_SRAV);
  endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between the control path and the shift unit.
interface shift_unit_if #(parameter int W = 32);
  localparam int AW = $clog2(W);

  logic          start;
  logic [W-1:0]  data_in;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [AW-1:0] shamt;
  logic [AW-1:0] rs_amt;
  logic          rot;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;
  logic          is_shift;

  modport master (
    output start, data_in, opcode, funct, shamt, rs_amt, rot,
    input  data_out, busy, done, is_shift
  );

  modport slave (
    input  start, data_in, opcode, funct, shamt, rs_amt, rot,
    output data_out, busy, done, is_shift
  );
endinterface

// File: rtl/shift_step.sv
// One iteration of the shifter: moves value by s (0..STEP) bits in the requested direction.
module shift_step
  import shift_pkg::*;
#(
  parameter int W    = 32,
  parameter int STEP = 1
) (
  input  logic [W-1:0]               value,
  input  shift_kind_t                kind,
  input  logic                       fill,
  input  logic [$clog2(STEP+1)-1:0]  s,
  output logic [W-1:0]               result
);

  logic [W-1:0] fill_mask;

  // Arithmetic fill comes from the sign captured at accept, not from the shifting value.
  always_comb begin
    fill_mask = ~({W{1'b1}} >> s);
    result    = value;
    case (kind)
      SK_SLL:  result = value << s;
      SK_SRL:  result = value >> s;
      SK_SRA:  result = (value >> s) | (fill ? fill_mask : '0);
      SK_ROR:  result = (value >> s) | (value << (W - int'(s)));
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative MIPS shift unit with start/busy/done handshake; non-shifts pass data_in through.
// Optional rotr/rotrv support is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit
  import shift_pkg::*;
#(
  parameter int W    = 32,
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  shift_unit_if.slave bus
);

  localparam int AW = $clog2(W);
  localparam int SW = $clog2(STEP + 1);

  state_t        state, next_state;
  logic [W-1:0]  work, step_result, data_out_q;
  logic [AW-1:0] cnt, cnt_next, dec_amt;
  logic [SW-1:0] s;
  shift_kind_t   kind, dec_kind;
  logic          fill, is_shift_q, dec_shift, accept, finish_now;

  assign dec_shift  = is_shift_instr(bus.opcode, bus.funct);
  assign dec_amt    = bus.funct[2] ? bus.rs_amt : bus.shamt;
  assign accept     = bus.start && (state == IDLE || state == DONE);
  assign finish_now = !dec_shift || (dec_amt == '0);

  always_comb begin
    dec_kind = SK_SLL;
    case (bus.funct[1:0])
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b10:   dec_kind = bus.rot ? SK_ROR : SK_SRL;
`else
      2'b10:   dec_kind = SK_SRL;
`endif
      2'b11:   dec_kind = SK_SRA;
      default: dec_kind = SK_SLL;
    endcase
  end

`ifndef SHIFT_UNIT_ROTATE_EN
  logic rot_unused;
  assign rot_unused = bus.rot;
`endif

  // The last iteration may move fewer than STEP bits.
  assign s        = (cnt < AW'(STEP)) ? SW'(cnt) : SW'(STEP);
  assign cnt_next = cnt - AW'(s);

  shift_step #(.W(W), .STEP(STEP)) u_step (
    .value  (work),
    .kind   (kind),
    .fill   (fill),
    .s      (s),
    .result (step_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.done = (state == DONE);
        if (bus.start) next_state = finish_now ? DONE : RUN;
        else           next_state = IDLE;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt_next == '0) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured only at accept so the control path may move on immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work       <= '0;
      cnt        <= '0;
      kind       <= SK_SLL;
      fill       <= 1'b0;
      data_out_q <= '0;
      is_shift_q <= 1'b0;
    end else if (accept) begin
      work       <= bus.data_in;
      kind       <= dec_kind;
      fill       <= bus.data_in[W-1];
      is_shift_q <= dec_shift;
      cnt        <= dec_shift ? dec_amt : '0;
      if (finish_now) data_out_q <= bus.data_in;
    end else if (state == RUN) begin
      work <= step_result;
      cnt  <= cnt_next;
      if (cnt_next == '0) data_out_q <= step_result;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.is_shift = is_shift_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: one STEP=1 and one STEP=4 instance, honours SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

  typedef struct {
    logic [31:0] data;
    logic        is_shift;
    int          lat;
  } exp_t;

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shift_unit_if #(.W(32)) b1 ();
  shift_unit_if #(.W(32)) b4 ();

  shift_unit #(.W(32), .STEP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  shift_unit #(.W(32), .STEP(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic exp_t model(input logic [31:0] d, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [4:0] rs, input logic r,
                                 input int step);
    exp_t        e;
    int          amt;
    logic [63:0] wide;
    e.is_shift = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 ||
                                   fn == 6'h04 || fn == 6'h06 || fn == 6'h07);
    amt    = fn[2] ? int'(rs) : int'(sh);
    e.data = d;
    e.lat  = 1;
    if (e.is_shift) begin
      wide = {d, d} >> amt;
      case (fn[1:0])
        2'b00:   e.data = d << amt;
        2'b11:   e.data = $signed(d) >>> amt;
        default: e.data = (ROT_EN && r) ? wide[31:0] : (d >> amt);
      endcase
      if (amt != 0) e.lat = (amt + step - 1) / step + 1;
    end
    return e;
  endfunction

  // Drives one request for a single accept edge and records the expected outcome.
  task automatic issue(input bit sel, input bit at_once, input logic [31:0] d, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] sh, input logic [4:0] rs, input logic r);
    if (!at_once) @(negedge clk);
    if (sel) begin
      b4.data_in = d; b4.opcode = op; b4.funct = fn; b4.shamt = sh; b4.rs_amt = rs; b4.rot = r;
      b4.start = 1'b1;
    end else begin
      b1.data_in = d; b1.opcode = op; b1.funct = fn; b1.shamt = sh; b1.rs_amt = rs; b1.rot = r;
      b1.start = 1'b1;
    end
    exp_q.push_back(model(d, op, fn, sh, rs, r, sel ? 4 : 1));
    @(negedge clk);
    b1.start = 1'b0;
    b4.start = 1'b0;
  endtask

  // Counts cycles (from the current negedge) until done; cyc = -1 on timeout.
  task automatic wait_done(input bit sel, output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      cyc++;
      if (sel ? b4.busy : b1.busy) busy_cyc++;
      if (sel ? b4.done : b1.done) return;
      @(negedge clk);
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b1.data_out !== 32'h0) begin failures++; $display("[TB] FAIL reset data_out: got %h expected 00000000", b1.data_out); end
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin failures++; $display("[TB] FAIL reset done: got %b expected 0", b1.done); end
    checks++; if (b4.is_shift !== 1'b0) begin failures++; $display("[TB] FAIL reset is_shift: got %b expected 0", b4.is_shift); end
  endtask

  task automatic test_sll();
    int cyc, bcyc;
    exp_t e;
    issue(0, 0, 32'h0000_0001, 6'h00, 6'h00, 5'd4, 5'd0, 1'b0);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== e.data) begin failures++; $display("[TB] FAIL sll data: got %h expected %h", b1.data_out, e.data); end
    checks++; if (cyc !== e.lat) begin failures++; $display("[TB] FAIL sll latency: got %0d expected %0d", cyc, e.lat); end
    checks++; if (bcyc !== 4) begin failures++; $display("[TB] FAIL sll busy cycles: got %0d expected 4", bcyc); end
    checks++; if (b1.is_shift !== 1'b1) begin failures++; $display("[TB] FAIL sll is_shift: got %b expected 1", b1.is_shift); end
  endtask

  task automatic test_sra_step4();
    int cyc, bcyc;
    exp_t e;
    issue(1, 0, 32'h8000_0000, 6'h00, 6'h03, 5'd31, 5'd0, 1'b0);
    wait_done(1, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b4.data_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sra4 data: got %h expected ffffffff", b4.data_out); end
    checks++; if (cyc !== 9) begin failures++; $display("[TB] FAIL sra4 latency: got %0d expected 9", cyc); end
    checks++; if (b4.data_out !== e.data) begin failures++; $display("[TB] FAIL sra4 model data: got %h expected %h", b4.data_out, e.data); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    exp_t e;
    issue(0, 0, 32'hF000_0000, 6'h00, 6'h06, 5'd3, 5'd8, 1'b0);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== 32'h00F0_0000) begin failures++; $display("[TB] FAIL srlv data: got %h expected 00f00000", b1.data_out); end
    checks++; if (cyc !== e.lat) begin failures++; $display("[TB] FAIL srlv latency: got %0d expected %0d", cyc, e.lat); end
    issue(0, 1, 32'hCAFE_F00D, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== e.data) begin failures++; $display("[TB] FAIL b2b data: got %h expected %h", b1.data_out, e.data); end
    checks++; if (cyc !== 1) begin failures++; $display("[TB] FAIL b2b latency: got %0d expected 1", cyc); end
  endtask

  task automatic test_nonshift_and_ignore();
    int cyc, bcyc;
    exp_t e;
    issue(0, 0, 32'h1234_5678, 6'h08, 6'h02, 5'd7, 5'd9, 1'b0);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== 32'h1234_5678) begin failures++; $display("[TB] FAIL addi data: got %h expected 12345678", b1.data_out); end
    checks++; if (b1.is_shift !== e.is_shift) begin failures++; $display("[TB] FAIL addi is_shift: got %b expected %b", b1.is_shift, e.is_shift); end
    checks++; if (cyc !== 1) begin failures++; $display("[TB] FAIL addi latency: got %0d expected 1", cyc); end
    issue(0, 0, 32'h0000_0003, 6'h00, 6'h00, 5'd6, 5'd0, 1'b0);
    b1.data_in = 32'hFFFF_FFFF; b1.shamt = 5'd1; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== e.data) begin failures++; $display("[TB] FAIL ignore data: got %h expected %h", b1.data_out, e.data); end
    checks++; if (cyc + 1 !== e.lat) begin failures++; $display("[TB] FAIL ignore latency: got %0d expected %0d", cyc + 1, e.lat); end
  endtask

  task automatic test_reset_mid_run();
    int   cyc, bcyc;
    bit   saw_done;
    exp_t e;
    issue(0, 0, 32'h0000_0001, 6'h00, 6'h00, 5'd20, 5'd0, 1'b0);
    void'(exp_q.pop_front());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (b1.data_out !== 32'h0) begin failures++; $display("[TB] FAIL midrst data: got %h expected 00000000", b1.data_out); end
    checks++; if (b1.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst busy: got %b expected 0", b1.busy); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (b1.done) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL midrst done pulse: got %b expected 0", saw_done); end
    issue(0, 0, 32'h0000_0003, 6'h00, 6'h00, 5'd20, 5'd0, 1'b0);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== 32'h0030_0000) begin failures++; $display("[TB] FAIL postrst data: got %h expected 00300000", b1.data_out); end
    checks++; if (cyc !== e.lat) begin failures++; $display("[TB] FAIL postrst latency: got %0d expected %0d", cyc, e.lat); end
  endtask

  task automatic test_rotate();
    int          cyc, bcyc;
    exp_t        e;
    logic [31:0] want;
    want = ROT_EN ? 32'h8000_0000 : 32'h0000_0000;
    issue(0, 0, 32'h0000_0001, 6'h00, 6'h02, 5'd1, 5'd0, 1'b1);
    wait_done(0, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b1.data_out !== want) begin failures++; $display("[TB] FAIL rotr data: got %h expected %h", b1.data_out, want); end
    want = ROT_EN ? 32'h6781_2345 : 32'h0001_2345;
    issue(1, 0, 32'h1234_5678, 6'h00, 6'h06, 5'd0, 5'd12, 1'b1);
    wait_done(1, cyc, bcyc);
    e = exp_q.pop_front();
    checks++; if (b4.data_out !== want) begin failures++; $display("[TB] FAIL rotrv data: got %h expected %h", b4.data_out, want); end
    checks++; if (cyc !== e.lat) begin failures++; $display("[TB] FAIL rotrv latency: got %0d expected %0d", cyc, e.lat); end
  endtask

  task automatic test_random();
    int          cyc, bcyc;
    exp_t        e;
    logic [5:0]  fn_tab [6] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [31:0] d;
    logic [5:0]  op;
    for (int n = 0; n < 12; n++) begin
      d  = $urandom;
      op = ($urandom_range(0, 5) == 0) ? 6'h23 : 6'h00;
      issue(n[0], 0, d, op, fn_tab[$urandom_range(0, 5)], 5'($urandom), 5'($urandom), 1'($urandom));
      wait_done(n[0], cyc, bcyc);
      e = exp_q.pop_front();
      checks++;
      if ((n[0] ? b4.data_out : b1.data_out) !== e.data) begin
        failures++;
        $display("[TB] FAIL random%0d data: got %h expected %h", n, n[0] ? b4.data_out : b1.data_out, e.data);
      end
      checks++; if (cyc !== e.lat) begin failures++; $display("[TB] FAIL random%0d latency: got %0d expected %0d", n, cyc, e.lat); end
    end
  endtask

  initial begin
    b1.start = 1'b0; b1.data_in = '0; b1.opcode = '0; b1.funct = '0; b1.shamt = '0; b1.rs_amt = '0; b1.rot = 1'b0;
    b4.start = 1'b0; b4.data_in = '0; b4.opcode = '0; b4.funct = '0; b4.shamt = '0; b4.rs_amt = '0; b4.rot = 1'b0;
    test_reset();
    test_sll();
    test_sra_step4();
    test_back_to_back();
    test_nonshift_and_ignore();
    test_reset_mid_run();
    test_rotate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
